// File: rtl/servo_pwm_gen.sv
// Servo PWM frame generator: tick-driven frame counter, double-buffered pulse width, output enable.
// Optional build macro SERVO_PWM_CLAMP_EN clamps accepted widths to [MIN_TICKS, MAX_TICKS].
module servo_pwm_gen #(
   parameter int unsigned PERIOD_TICKS  = 800,
   parameter int unsigned MIN_TICKS     = 40,
   parameter int unsigned MAX_TICKS     = 80,
   parameter int unsigned DEFAULT_TICKS = 60
) (
   input  logic       clk,
   input  logic       rst,
   input  logic       tick_en,
   input  logic       enable,
   input  logic       cmd_valid,
   input  logic [9:0] cmd_width,
   output logic       cmd_ready,
   output logic       pwm_out,
   output logic       frame_start
);

   typedef enum logic [1:0] {
      IDLE = 2'd0,
      HIGH = 2'd1,
      LOW  = 2'd2
   } state_t;

   localparam logic [9:0] LAST_CNT = 10'(PERIOD_TICKS - 1);
   localparam logic [9:0] MIN_W    = 10'(MIN_TICKS);
   localparam logic [9:0] MAX_W    = 10'(MAX_TICKS);
   localparam logic [9:0] DEF_W    = 10'(DEFAULT_TICKS);

   function automatic logic [9:0] store_width(input logic [9:0] w);
`ifdef SERVO_PWM_CLAMP_EN
      if (w < MIN_W) begin
         return MIN_W;
      end else if (w > MAX_W) begin
         return MAX_W;
      end else begin
         return w;
      end
`else
      return w;
`endif
   endfunction

   state_t     state_r, state_s;
   logic [9:0] cnt_r, cnt_s, cnt_inc_s;
   logic [9:0] active_width_r, active_width_s, load_width_s;
   logic [9:0] pending_r, pending_s;
   logic       pending_valid_r, pending_valid_s;
   logic       pwm_out_r, frame_start_r, frame_start_s, cmd_ready_r;
   logic       boundary_s, accept_s;

   // Next-state, frame counter and pending/active width buffering
   always_comb begin
      state_s         = state_r;
      cnt_s           = cnt_r;
      cnt_inc_s       = cnt_r + 10'd1;
      active_width_s  = active_width_r;
      load_width_s    = active_width_r;
      pending_s       = pending_r;
      pending_valid_s = pending_valid_r;
      frame_start_s   = 1'b0;
      boundary_s      = 1'b0;
      accept_s        = cmd_valid && cmd_ready_r;

      case (state_r)
         IDLE: begin
            cnt_s = 10'd0;
            if (enable && tick_en) begin
               boundary_s = 1'b1;
            end else begin
               state_s = IDLE;
            end
         end
         HIGH, LOW: begin
            if (!enable) begin
               state_s = IDLE;
               cnt_s   = 10'd0;
            end else if (tick_en) begin
               if (cnt_r == LAST_CNT) begin
                  boundary_s = 1'b1;
               end else begin
                  cnt_s   = cnt_inc_s;
                  state_s = (cnt_inc_s < active_width_r) ? HIGH : LOW;
               end
            end else begin
               state_s = state_r;
            end
         end
         default: begin
            state_s = IDLE;
            cnt_s   = 10'd0;
         end
      endcase

      // A frame boundary swaps in the pending width before deciding the first tick's level
      if (boundary_s) begin
         if (pending_valid_r) begin
            load_width_s    = pending_r;
            pending_valid_s = 1'b0;
         end else begin
            load_width_s = active_width_r;
         end
         cnt_s          = 10'd0;
         active_width_s = load_width_s;
         frame_start_s  = 1'b1;
         state_s        = (load_width_s != 10'd0) ? HIGH : LOW;
      end else begin
         frame_start_s = 1'b0;
      end

      // Accept only when pending is empty, so it never collides with a boundary clear
      if (accept_s) begin
         pending_s       = store_width(cmd_width);
         pending_valid_s = 1'b1;
      end else begin
         pending_s = pending_s;
      end
   end

   // State, counter, buffers and registered outputs
   always_ff @(posedge clk) begin
      if (rst) begin
         state_r         <= IDLE;
         cnt_r           <= 10'd0;
         active_width_r  <= DEF_W;
         pending_r       <= 10'd0;
         pending_valid_r <= 1'b0;
         pwm_out_r       <= 1'b0;
         frame_start_r   <= 1'b0;
         cmd_ready_r     <= 1'b1;
      end else begin
         state_r         <= state_s;
         cnt_r           <= cnt_s;
         active_width_r  <= active_width_s;
         pending_r       <= pending_s;
         pending_valid_r <= pending_valid_s;
         pwm_out_r       <= (state_s == HIGH);
         frame_start_r   <= frame_start_s;
         cmd_ready_r     <= !pending_valid_s;
      end
   end

   assign pwm_out     = pwm_out_r;
   assign frame_start = frame_start_r;
   assign cmd_ready   = cmd_ready_r;

endmodule

// File: tb/tb_servo_pwm_gen.sv
// Directed bench for servo_pwm_gen: PERIOD=20, MIN=2, MAX=8, DEFAULT=5 ticks, tick_en every 4 clk.
module tb_servo_pwm_gen;

   logic       clk;
   logic       rst;
   logic       tick_en;
   logic       enable;
   logic       cmd_valid;
   logic [9:0] cmd_width;
   logic       cmd_ready;
   logic       pwm_out;
   logic       frame_start;

   int vectors;
   int miscompares;
   int phase;

   servo_pwm_gen #(
      .PERIOD_TICKS (20),
      .MIN_TICKS    (2),
      .MAX_TICKS    (8),
      .DEFAULT_TICKS(5)
   ) dut (
      .clk        (clk),
      .rst        (rst),
      .tick_en    (tick_en),
      .enable     (enable),
      .cmd_valid  (cmd_valid),
      .cmd_width  (cmd_width),
      .cmd_ready  (cmd_ready),
      .pwm_out    (pwm_out),
      .frame_start(frame_start)
   );

   initial begin
      clk = 1'b0;
      forever #5 clk = ~clk;
   end

   initial begin
      tick_en = 1'b0;
      phase   = 0;
      forever begin
         @(posedge clk);
         #1;
         phase   = (phase + 1) % 4;
         tick_en = (phase == 3);
      end
   end

   initial begin
      #1000000;
      $display("FAIL watchdog: simulation did not finish, time=%0t", $time);
      $fatal(1);
   end

   // Called at a negedge. Waits for a frame_start sample, then counts high samples until the next one.
   task automatic measure(output int high, output int period, output int waited,
                          output logic rdy_after, output logic rdy_before);
      high = 0; period = 0; waited = 0; rdy_after = 1'b0; rdy_before = 1'b0;
      while (frame_start !== 1'b1 && waited < 400) begin
         @(negedge clk);
         waited++;
      end
      if (frame_start !== 1'b1) begin
         vectors++; miscompares++;
         $display("FAIL frame_start_wait: got no frame_start, required one within 400 clk");
         return;
      end
      do begin
         high += (pwm_out === 1'b1) ? 1 : 0;
         rdy_before = cmd_ready;
         @(negedge clk);
         period++;
         if (period == 1) rdy_after = cmd_ready;
      end while (frame_start !== 1'b1 && period < 400);
   endtask

   task automatic offer(input logic [9:0] w);
      @(posedge clk); #1;
      cmd_valid = 1'b1; cmd_width = w;
      @(posedge clk); #1;
      cmd_valid = 1'b0;
   endtask

   task automatic test_reset;
      rst = 1'b1; enable = 1'b0; cmd_valid = 1'b0; cmd_width = 10'd0;
      repeat (3) @(negedge clk);
      vectors++;
      if (pwm_out !== 1'b0) begin miscompares++; $display("FAIL reset_pwm: got %b, required 0", pwm_out); end
      vectors++;
      if (frame_start !== 1'b0) begin miscompares++; $display("FAIL reset_fs: got %b, required 0", frame_start); end
      vectors++;
      if (cmd_ready !== 1'b1) begin miscompares++; $display("FAIL reset_ready: got %b, required 1", cmd_ready); end
      @(posedge clk); #1;
      rst = 1'b0; enable = 1'b1;
      @(negedge clk);
   endtask

   task automatic test_basic;
      int h, p, w;
      logic ra, rb;
      for (int i = 0; i < 2; i++) begin
         measure(h, p, w, ra, rb);
         vectors++;
         if (p !== 80) begin miscompares++; $display("FAIL basic_period[%0d]: got %0d clk, required 80", i, p); end
         vectors++;
         if (h !== 20) begin miscompares++; $display("FAIL basic_high[%0d]: got %0d clk, required 20", i, h); end
      end
   endtask

   task automatic test_cmd_midframe;
      int h0, p0, w0, h1, p1, w1;
      logic ra0, rb0, ra1, rb1;
      fork
         measure(h0, p0, w0, ra0, rb0);
         begin
            repeat (10) @(posedge clk);
            offer(10'd7);
         end
      join
      measure(h1, p1, w1, ra1, rb1);
      vectors++;
      if (h0 !== 20) begin miscompares++; $display("FAIL mid_cur_high: got %0d clk, required 20", h0); end
      vectors++;
      if (rb0 !== 1'b0) begin miscompares++; $display("FAIL mid_ready_pending: got %b, required 0", rb0); end
      vectors++;
      if (h1 !== 28) begin miscompares++; $display("FAIL mid_next_high: got %0d clk, required 28", h1); end
      vectors++;
      if (p1 !== 80) begin miscompares++; $display("FAIL mid_next_period: got %0d clk, required 80", p1); end
      vectors++;
      if (ra1 !== 1'b1) begin miscompares++; $display("FAIL mid_ready_after_fs: got %b, required 1", ra1); end
   endtask

   task automatic test_back_to_back;
      int hi[3];
      int per[3];
      int exp_hi[3];
      int w, n;
      logic ra, rb, held;
      exp_hi = '{28, 12, 24};
      held = 1'b1;
      fork
         begin
            for (int i = 0; i < 3; i++) measure(hi[i], per[i], w, ra, rb);
         end
         begin
            repeat (10) @(posedge clk);
            offer(10'd3);
            repeat (9) @(posedge clk);
            #1;
            cmd_valid = 1'b1; cmd_width = 10'd6;
            @(negedge clk);
            held = cmd_ready;
            n = 0;
            while (cmd_ready !== 1'b1 && n < 200) begin
               @(negedge clk);
               n++;
            end
            @(posedge clk); #1;
            cmd_valid = 1'b0;
         end
      join
      vectors++;
      if (held !== 1'b0) begin miscompares++; $display("FAIL b2b_held_off: cmd_ready got %b, required 0", held); end
      for (int i = 0; i < 3; i++) begin
         vectors++;
         if (hi[i] !== exp_hi[i]) begin
            miscompares++;
            $display("FAIL b2b_high[%0d]: got %0d clk, required %0d", i, hi[i], exp_hi[i]);
         end
      end
   endtask

   task automatic test_width_limits;
      int hi[5];
      int per[5];
      int exp_hi[5];
      int w;
      logic ra, rb;
      logic [9:0] wa, wb;
`ifdef SERVO_PWM_CLAMP_EN
      wa = 10'd1; wb = 10'd50;
      exp_hi = '{24, 8, 32, 32, 20};
`else
      wa = 10'd0; wb = 10'd25;
      exp_hi = '{24, 0, 80, 80, 20};
`endif
      fork
         begin
            for (int i = 0; i < 5; i++) measure(hi[i], per[i], w, ra, rb);
         end
         begin
            repeat (4) @(posedge clk);
            offer(wa);
            repeat (83) @(posedge clk);
            offer(wb);
            repeat (158) @(posedge clk);
            offer(10'd5);
         end
      join
      for (int i = 0; i < 5; i++) begin
         vectors++;
         if (hi[i] !== exp_hi[i] || per[i] !== 80) begin
            miscompares++;
            $display("FAIL width_frame[%0d]: got high=%0d period=%0d, required high=%0d period=80",
                     i, hi[i], per[i], exp_hi[i]);
         end
      end
   endtask

   task automatic test_enable_drop;
      int n, bad, h, p, w;
      logic ra, rb;
      n = 0;
      while (n < 3) begin
         @(negedge clk);
         if (tick_en === 1'b1) n++;
      end
      enable = 1'b0;
      @(negedge clk);
      vectors++;
      if (pwm_out !== 1'b0) begin miscompares++; $display("FAIL en_drop_pwm: got %b, required 0", pwm_out); end
      vectors++;
      if (dut.cnt_r !== 10'd0) begin miscompares++; $display("FAIL en_drop_cnt: got %0d, required 0", dut.cnt_r); end
      bad = 0;
      repeat (12) begin
         @(negedge clk);
         if (pwm_out !== 1'b0 || frame_start !== 1'b0) bad++;
      end
      vectors++;
      if (bad !== 0) begin miscompares++; $display("FAIL en_idle_quiet: got %0d active samples, required 0", bad); end
      enable = 1'b1;
      measure(h, p, w, ra, rb);
      vectors++;
      if (w < 1 || w > 4) begin miscompares++; $display("FAIL en_restart_delay: got %0d clk, required 1..4", w); end
      vectors++;
      if (h !== 20 || p !== 80) begin
         miscompares++;
         $display("FAIL en_restart_frame: got high=%0d period=%0d, required high=20 period=80", h, p);
      end
   endtask

   task automatic test_reset_midframe;
      int n, h, p, w;
      logic ra, rb;
      offer(10'd9);
      @(negedge clk);
      n = 0;
      while (frame_start !== 1'b1 && n < 200) begin
         @(negedge clk);
         n++;
      end
      @(negedge clk);
      while (tick_en !== 1'b1 && n < 400) begin
         @(negedge clk);
         n++;
      end
      vectors++;
      if (pwm_out !== 1'b1) begin miscompares++; $display("FAIL rstmid_pre_high: got %b, required 1", pwm_out); end
      rst = 1'b1; cmd_valid = 1'b1; cmd_width = 10'd3;
      @(negedge clk);
      vectors++;
      if (pwm_out !== 1'b0 || frame_start !== 1'b0 || cmd_ready !== 1'b1) begin
         miscompares++;
         $display("FAIL rstmid_outputs: got pwm=%b fs=%b ready=%b, required 0 0 1", pwm_out, frame_start, cmd_ready);
      end
      vectors++;
      if (dut.cnt_r !== 10'd0 || dut.state_r !== 2'd0 || dut.pending_valid_r !== 1'b0) begin
         miscompares++;
         $display("FAIL rstmid_state: got cnt=%0d state=%0d pv=%b, required 0 0 0",
                  dut.cnt_r, dut.state_r, dut.pending_valid_r);
      end
      vectors++;
      if (dut.active_width_r !== 10'd5) begin
         miscompares++;
         $display("FAIL rstmid_width: got %0d, required 5", dut.active_width_r);
      end
      @(negedge clk);
      vectors++;
      if (cmd_ready !== 1'b1) begin miscompares++; $display("FAIL rstmid_no_accept: got %b, required 1", cmd_ready); end
      rst = 1'b0; cmd_valid = 1'b0;
      measure(h, p, w, ra, rb);
      vectors++;
      if (h !== 20 || p !== 80) begin
         miscompares++;
         $display("FAIL rstmid_after: got high=%0d period=%0d, required high=20 period=80", h, p);
      end
   endtask

   initial begin
      vectors     = 0;
      miscompares = 0;
      rst       = 1'b1;
      enable    = 1'b0;
      cmd_valid = 1'b0;
      cmd_width = 10'd0;
      test_reset();
      test_basic();
      test_cmd_midframe();
      test_back_to_back();
      test_width_limits();
      test_enable_drop();
      test_reset_midframe();
      $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
      $finish;
   end

endmodule

// File: doc/servo_pwm_gen.md
SERVO_PWM_GEN -- requirements
Module: servo_pwm_gen

Interface
REQ-001 The block SHALL use reset rst, synchronous, active-high, and clock clk.
REQ-002 The block SHALL provide the following parameters:
- PERIOD_TICKS, default 800, PWM frame length in tick_en pulses (20 ms at 40 kHz).
- MIN_TICKS, default 40, minimum legal pulse width (1.0 ms).
- MAX_TICKS, default 80, maximum legal pulse width (2.0 ms).
- DEFAULT_TICKS, default 60, pulse width after reset (1.5 ms, servo centre).
REQ-003 The block SHALL provide the following ports:
- clk  in  1  system clock, 100 MHz.
- rst  in  1  synchronous active-high reset.
- tick_en  in  1  single-cycle clock-enable pulse from the 40 kHz divider.
- enable  in  1  output enable; 0 forces pwm_out low.
- cmd_valid  in  1  new pulse width offered.
- cmd_width  in  10  requested pulse width in ticks.
- cmd_ready  out  1  pending register empty; command can be accepted.
- pwm_out  out  1  registered servo PWM signal.
- frame_start  out  1  single-cycle pulse on each frame boundary.

Function
REQ-004 The frame counter cnt (10-bit) SHALL advance only on cycles with tick_en=1; all other cycles hold the state.
REQ-005 State machine: IDLE, HIGH, LOW.
- IDLE: pwm_out=0, cnt=0.
- Leave IDLE on the first tick_en with enable=1; this is a frame boundary.
REQ-006 Frame boundary behaviour:
- Occurs on a tick_en with cnt=PERIOD_TICKS-1 (HIGH or LOW), or on leaving IDLE.
- cnt<=0.
- If pending is valid, active_width<=pending and pending is cleared.
- frame_start=1 for that one cycle.
- Next state is HIGH if active_width (as loaded) >0, else LOW.
REQ-007 On a non-boundary tick, cnt<=cnt+1, and the state SHALL be HIGH when cnt+1 < active_width, otherwise LOW.
REQ-008 pwm_out SHALL equal (state==HIGH) and be registered, changing the cycle after the tick that causes the transition. Each frame is exactly PERIOD_TICKS ticks, with the high time equal to active_width ticks.
REQ-009 Width boundaries:
- active_width=0: pwm_out stays low for the whole frame.
- active_width >= PERIOD_TICKS: pwm_out stays high for the whole frame with no low glitch at the boundary.
REQ-010 Command handshake:
- cmd_ready = !pending_valid.
- The command is accepted on a cycle with cmd_valid && cmd_ready, which loads pending and sets pending_valid.
- cmd_width is sampled only at accept.
REQ-011 Acceptance on the same cycle as a frame boundary SHALL fill pending only; the value takes effect at the next boundary.
REQ-012 A boundary that clears pending SHALL raise cmd_ready on the following cycle. Only the most recent accepted command per frame is applied.
REQ-013 enable deassert mid-frame SHALL move the block to IDLE on the next clk:
- pwm_out is 0 one cycle later.
- cnt=0.
- pending and active_width are retained.

Reset
REQ-014 While rst=1 the block SHALL set:
- state=IDLE, cnt=0, pwm_out=0, frame_start=0.
- pending_valid=0, cmd_ready=1.
- active_width=DEFAULT_TICKS.
REQ-015 Reset mid-frame SHALL take priority over tick_en, enable and cmd_valid on the same cycle.

Configuration
REQ-016 With macro SERVO_PWM_CLAMP_EN defined, an accepted cmd_width SHALL be clamped to [MIN_TICKS, MAX_TICKS] before storage in pending.
REQ-017 Without SERVO_PWM_CLAMP_EN, cmd_width SHALL be stored unmodified, so widths 0 and >= PERIOD_TICKS are reachable and follow REQ-009.

Verification
REQ-018 The bench SHALL cover the following directed scenarios, each with PERIOD_TICKS=20, MIN_TICKS=2, MAX_TICKS=8, DEFAULT_TICKS=5, and tick_en every 4 clk:
- Reset then enable=1 -> frame_start every 80 clk; pwm_out high 20 clk per frame (5 ticks).
- cmd_width=7 accepted mid-frame -> current frame keeps 5 ticks high; next frame is 7 ticks high; cmd_ready returns 1 one cycle after that frame_start.
- Two commands, 3 then 6, with the second offered while cmd_ready=0 -> second is held off; 3 is applied, then 6 the following frame.
- Clamp defined: cmd_width=1 -> 2 ticks high; cmd_width=50 -> 8 ticks high. Macro undefined: 0 -> pwm_out never high; 25 -> pwm_out continuously high across boundaries.
- enable dropped at tick 3 of a frame -> pwm_out=0 within 2 clk, cnt=0. Re-enable -> a new full frame starts at the next tick with the retained width.
- rst asserted mid-HIGH together with tick_en and cmd_valid -> all REQ-014 values; command not accepted.
